// File: rtl/fb_page_arbiter_if.sv
// Scan-out, host-write and RAM port bundle for the frame-buffer page arbiter.
interface fb_page_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 24
);
    // scan-out read channel
    logic              SCAN_REQ_I;
    logic [ADDR_W-1:0] SCAN_ADDR_I;
    logic [DATA_W-1:0] SCAN_DATA_O;
    logic              SCAN_VALID_O;

    // host write channel (valid/ready)
    logic              WR_VALID_I;
    logic              WR_READY_O;
    logic [ADDR_W-1:0] WR_ADDR_I;
    logic [DATA_W-1:0] WR_DATA_I;

    // single-port RAM: {page, pixel} addressing, synchronous 1-cycle read
    logic [ADDR_W:0]   RAM_ADDR_O;
    logic              RAM_WE_O;
    logic [DATA_W-1:0] RAM_WDATA_O;
    logic [DATA_W-1:0] RAM_RDATA_I;

    // request side: scan-out, host and RAM model
    modport master (
        output SCAN_REQ_I, SCAN_ADDR_I, WR_VALID_I, WR_ADDR_I, WR_DATA_I, RAM_RDATA_I,
        input  SCAN_DATA_O, SCAN_VALID_O, WR_READY_O, RAM_ADDR_O, RAM_WE_O, RAM_WDATA_O
    );

    // arbiter side
    modport slave (
        input  SCAN_REQ_I, SCAN_ADDR_I, WR_VALID_I, WR_ADDR_I, WR_DATA_I, RAM_RDATA_I,
        output SCAN_DATA_O, SCAN_VALID_O, WR_READY_O, RAM_ADDR_O, RAM_WE_O, RAM_WDATA_O
    );
endinterface

// File: rtl/fb_page_arbiter.sv
// Double-buffered frame-buffer arbiter: shares one single-port RAM between
// scan-out reads, a back-page colour-fill engine and host writes, and swaps
// front/back pages only at scan frame boundaries.
module fb_page_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 24
) (
    input  logic              CLK_I,
    input  logic              RSTN_I,
    fb_page_arbiter_if.slave  bus,
    input  logic              FRAME_END_I,
    input  logic              SWAP_REQ_I,
    input  logic              FILL_REQ_I,
    input  logic [DATA_W-1:0] FILL_COLOR_I,
    output logic              SWAP_PEND_O,
    output logic              BUSY_O,
    output logic              FRONT_PAGE_O
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              front_q, front_d;
    logic              pend_q, pend_d;
    logic              scan_valid_q;

    logic              wr_ready;
    logic              wr_fire;
    logic [ADDR_W:0]   ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;

    // host may only write while idle and not displaced by a scan read
    assign wr_ready = ~bus.SCAN_REQ_I & (state_q == ST_IDLE);
    assign wr_fire  = bus.WR_VALID_I & wr_ready;

    // state and page registers
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            color_q      <= '0;
            front_q      <= 1'b0;
            pend_q       <= 1'b0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            front_q      <= front_d;
            pend_q       <= pend_d;
            scan_valid_q <= bus.SCAN_REQ_I;
        end
    end

    // fill sequencing and frame-boundary page swap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        front_d = front_q;
        pend_d  = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (FILL_REQ_I) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    color_d = FILL_COLOR_I;
                end
            end
            ST_FILL: begin
                // a scan read steals the RAM port; the fill simply waits
                if (!bus.SCAN_REQ_I) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // never show a half-filled page: swaps wait for an idle frame end
        if (FRAME_END_I && (pend_q || SWAP_REQ_I) && (state_q == ST_IDLE)) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end else if (SWAP_REQ_I) begin
            pend_d  = 1'b1;
        end
    end

    // RAM port mux, priority scan > fill > host; writes use the pre-swap front
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (bus.SCAN_REQ_I) begin
            ram_addr  = {front_q, bus.SCAN_ADDR_I};
        end else if (state_q == ST_FILL) begin
            ram_addr  = {~front_q, cnt_q};
            ram_we    = 1'b1;
            ram_wdata = color_q;
        end else if (wr_fire) begin
            ram_addr  = {~front_q, bus.WR_ADDR_I};
            ram_we    = 1'b1;
            ram_wdata = bus.WR_DATA_I;
        end
    end

    assign bus.RAM_ADDR_O   = ram_addr;
    assign bus.RAM_WE_O     = ram_we;
    assign bus.RAM_WDATA_O  = ram_wdata;
    assign bus.WR_READY_O   = wr_ready;
    assign bus.SCAN_DATA_O  = bus.RAM_RDATA_I;
    assign bus.SCAN_VALID_O = scan_valid_q;

    assign SWAP_PEND_O  = pend_q;
    assign BUSY_O       = (state_q == ST_FILL);
    assign FRONT_PAGE_O = front_q;

endmodule

// File: tb/tb_fb_page_arbiter.sv
// Directed bench for fb_page_arbiter: expected RAM writes are queued as the
// stimulus is driven and checked by a write monitor as the DUT issues them.
module tb_fb_page_arbiter;

    logic        clk;
    logic        rst_n;
    logic        frame_end;
    logic        swap_req;
    logic        fill_req;
    logic [23:0] fill_color;
    logic        swap_pend;
    logic        busy;
    logic        front_page;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [34:0] exp_q[$];
    logic [23:0] mem [2048];

    fb_page_arbiter_if #(.ADDR_W(10), .DATA_W(24)) bus ();

    fb_page_arbiter #(.ADDR_W(10), .DATA_W(24)) dut (
        .CLK_I        (clk),
        .RSTN_I       (rst_n),
        .bus          (bus.slave),
        .FRAME_END_I  (frame_end),
        .SWAP_REQ_I   (swap_req),
        .FILL_REQ_I   (fill_req),
        .FILL_COLOR_I (fill_color),
        .SWAP_PEND_O  (swap_pend),
        .BUSY_O       (busy),
        .FRONT_PAGE_O (front_page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural single-port RAM, synchronous read
    always @(posedge clk) begin
        if (bus.RAM_WE_O) mem[bus.RAM_ADDR_O] <= bus.RAM_WDATA_O;
        bus.RAM_RDATA_I <= mem[bus.RAM_ADDR_O];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] ent(input logic [10:0] a, input logic [23:0] d);
        return {a, d};
    endfunction

    // write monitor: every RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.RAM_WE_O) begin
            logic [34:0] e;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", bus.RAM_ADDR_O);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ram_addr", 32'(bus.RAM_ADDR_O), 32'(e[34:24]));
                check("ram_wdata", 32'(bus.RAM_WDATA_O), 32'(e[23:0]));
            end
            wr_count++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int base;
        bit done;
        logic prev_we;

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rst_n = 1'b0;
        frame_end = 1'b0; swap_req = 1'b0; fill_req = 1'b0; fill_color = '0;
        bus.SCAN_REQ_I = 1'b0; bus.SCAN_ADDR_I = '0;
        bus.WR_VALID_I = 1'b0; bus.WR_ADDR_I = '0; bus.WR_DATA_I = '0;

        // 1: reset state
        repeat (3) cyc();
        smp();
        check("rst_front", 32'(front_page), 0);
        check("rst_wr_ready", 32'(bus.WR_READY_O), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pend", 32'(swap_pend), 0);
        check("rst_we", 32'(bus.RAM_WE_O), 0);
        check("rst_scan_valid", 32'(bus.SCAN_VALID_O), 0);
        cyc();
        rst_n = 1'b1;

        // 2: host write px5 to back page, then scan read px5 from front page
        cyc();
        bus.WR_VALID_I = 1'b1; bus.WR_ADDR_I = 10'd5; bus.WR_DATA_I = 24'h0000FF;
        exp_q.push_back(ent(11'h405, 24'h0000FF));
        smp();
        check("wr_ready_idle", 32'(bus.WR_READY_O), 1);
        check("wr_we", 32'(bus.RAM_WE_O), 1);
        cyc();
        bus.WR_VALID_I = 1'b0;
        bus.SCAN_REQ_I = 1'b1; bus.SCAN_ADDR_I = 10'd5;
        smp();
        check("scan_addr", 32'(bus.RAM_ADDR_O), 32'h005);
        check("scan_we", 32'(bus.RAM_WE_O), 0);
        check("scan_valid_early", 32'(bus.SCAN_VALID_O), 0);
        cyc();
        bus.SCAN_REQ_I = 1'b0;
        smp();
        check("scan_valid", 32'(bus.SCAN_VALID_O), 1);
        cyc();
        smp();
        check("scan_valid_drop", 32'(bus.SCAN_VALID_O), 0);

        // 3: scan blocks a concurrent host write; it completes next cycle
        cyc();
        bus.SCAN_REQ_I = 1'b1; bus.SCAN_ADDR_I = 10'd9;
        bus.WR_VALID_I = 1'b1; bus.WR_ADDR_I = 10'd6; bus.WR_DATA_I = 24'h123456;
        smp();
        check("conflict_ready", 32'(bus.WR_READY_O), 0);
        check("conflict_we", 32'(bus.RAM_WE_O), 0);
        cyc();
        bus.SCAN_REQ_I = 1'b0;
        exp_q.push_back(ent(11'h406, 24'h123456));
        smp();
        check("retry_ready", 32'(bus.WR_READY_O), 1);
        cyc();
        bus.WR_VALID_I = 1'b0;

        // 4: fill back page with scan stealing 1 cycle in 4
        fill_req = 1'b1; fill_color = 24'h00FF00;
        for (int i = 0; i < 1024; i++) exp_q.push_back(ent({1'b1, 10'(i)}, 24'h00FF00));
        base = wr_count;
        smp();
        done = 1'b0;
        prev_we = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            cyc();
            fill_req = (c == 100);
            fill_color = 24'hABCDEF;
            bus.SCAN_REQ_I = (c % 4 == 0);
            bus.SCAN_ADDR_I = 10'(c);
            smp();
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (bus.SCAN_REQ_I)
                    check("fill_scan_addr", 32'(bus.RAM_ADDR_O), 32'(c % 1024));
                prev_we = bus.RAM_WE_O;
            end
        end
        check("fill_done", 32'(busy), 0);
        check("fill_writes", 32'(wr_count - base), 1024);
        check("fill_last_write_before_idle", 32'(prev_we), 1);
        check("fill_queue_empty", 32'(exp_q.size()), 0);
        cyc();
        bus.SCAN_REQ_I = 1'b0; fill_req = 1'b0;

        // 5a: swap at a frame end; a write in that cycle targets the old back page
        swap_req = 1'b1;
        smp();
        check("swap_pend_early", 32'(swap_pend), 0);
        cyc();
        smp();
        check("swap_pend_set", 32'(swap_pend), 1);
        cyc();
        cyc();
        swap_req = 1'b0;
        frame_end = 1'b1;
        bus.WR_VALID_I = 1'b1; bus.WR_ADDR_I = 10'd7; bus.WR_DATA_I = 24'h00BEEF;
        exp_q.push_back(ent(11'h407, 24'h00BEEF));
        smp();
        check("swap_front_before", 32'(front_page), 0);
        cyc();
        frame_end = 1'b0; bus.WR_VALID_I = 1'b0;
        smp();
        check("swap_front", 32'(front_page), 1);
        check("swap_pend_clear", 32'(swap_pend), 0);
        cyc();
        bus.SCAN_REQ_I = 1'b1; bus.SCAN_ADDR_I = 10'd5;
        smp();
        check("scan_new_front_addr", 32'(bus.RAM_ADDR_O), 32'h405);
        cyc();
        bus.SCAN_REQ_I = 1'b0;
        smp();
        check("scan_fill_data", 32'(bus.SCAN_DATA_O), 32'h00FF00);

        // 5b: swap requested during a fill waits for a frame end after the fill
        cyc();
        fill_req = 1'b1; fill_color = 24'h0000AA;
        for (int i = 0; i < 1024; i++) exp_q.push_back(ent({1'b0, 10'(i)}, 24'h0000AA));
        cyc();
        fill_req = 1'b0; swap_req = 1'b1;
        cyc();
        swap_req = 1'b0; frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        smp();
        check("fill_swap_front_hold", 32'(front_page), 1);
        check("fill_swap_pending", 32'(swap_pend), 1);
        done = 1'b0;
        for (int c = 0; c < 1200 && !done; c++) begin
            cyc();
            smp();
            if (!busy) done = 1'b1;
        end
        check("fill2_done", 32'(busy), 0);
        check("fill2_front_hold", 32'(front_page), 1);
        check("fill2_pending", 32'(swap_pend), 1);
        check("fill2_queue_empty", 32'(exp_q.size()), 0);
        cyc();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        smp();
        check("fill2_swap_front", 32'(front_page), 0);
        check("fill2_swap_pend_clear", 32'(swap_pend), 0);

        // swap request coincident with frame end swaps immediately
        cyc();
        swap_req = 1'b1; frame_end = 1'b1;
        cyc();
        swap_req = 1'b0; frame_end = 1'b0;
        smp();
        check("direct_swap_front", 32'(front_page), 1);
        check("direct_swap_pend", 32'(swap_pend), 0);

        // 6: reset mid-fill when the counter reaches 300
        cyc();
        fill_req = 1'b1; fill_color = 24'h112233;
        for (int i = 0; i < 1024; i++) exp_q.push_back(ent({1'b0, 10'(i)}, 24'h112233));
        base = wr_count;
        cyc();
        fill_req = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            smp();
            #1;
            if (wr_count - base >= 300) done = 1'b1;
        end
        check("mid_fill_count", 32'(wr_count - base), 300);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_we", 32'(bus.RAM_WE_O), 0);
        check("mid_rst_front", 32'(front_page), 0);
        check("mid_rst_scan_valid", 32'(bus.SCAN_VALID_O), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        smp();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_ready", 32'(bus.WR_READY_O), 1);
        check("post_rst_pend", 32'(swap_pend), 0);
        cyc();
        bus.WR_VALID_I = 1'b1; bus.WR_ADDR_I = 10'd9; bus.WR_DATA_I = 24'hC0FFEE;
        exp_q.push_back(ent(11'h409, 24'hC0FFEE));
        cyc();
        bus.WR_VALID_I = 1'b0;
        cyc();
        smp();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
